// File: rtl/spi_master_fifo.sv
// rtl/spi_master_fifo.sv - SPI master with runtime word length, CPOL/CPHA, SCLK divider, chip selects and TX/RX FIFOs
module spi_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] wr_data,
  input  logic         wr_en,
  output logic         full,
  output logic [W-1:0] rd_data,
  input  logic         rd_en,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push    = wr_en & ~full;
  assign pop     = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end
endmodule

module spi_master_fifo #(
  parameter int DATA_W = 32,
  parameter int NCS    = 4,
  parameter int DIV_W  = 8,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DIV_W-1:0]       cfg_div,
  input  logic                   cfg_cpol,
  input  logic                   cfg_cpha,
  input  logic [5:0]             cfg_len,
  input  logic [$clog2(NCS)-1:0] cfg_cs,
  input  logic [DATA_W-1:0]      tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic [DATA_W-1:0]      rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   busy,
  input  logic                   miso,
  output logic                   mosi,
  output logic                   sclk,
  output logic [NCS-1:0]         cs_n
);
  localparam int IW = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;
  state_t state, state_nxt;

  logic [DIV_W-1:0]  div_cnt, div_l;
  logic [IW:0]       edge_cnt;
  logic [IW-1:0]     msb_l, msb_cfg, msb_use;
  logic              cpha_l, cpha_use;
  logic [DATA_W-1:0] tx_sh, rx_sh, tx_next, rx_next, tx_word, rx_word;
  logic              tx_empty, tx_full, rx_empty, rx_full;
  logic              tick, start, load, rx_push, sample;

  spi_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .wr_data(tx_data), .wr_en(tx_valid & tx_ready), .full(tx_full),
    .rd_data(tx_word), .rd_en(start | load), .empty(tx_empty)
  );

  spi_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .wr_data(rx_word), .wr_en(rx_push), .full(rx_full),
    .rd_data(rx_data), .rd_en(rx_ready), .empty(rx_empty)
  );

  assign tx_ready = ~tx_full & ~rst;
  assign rx_valid = ~rx_empty;
  assign busy     = (state != IDLE);
  assign tick     = (div_cnt == div_l);
  assign tx_next  = tx_sh << 1;
  assign rx_next  = {rx_sh[DATA_W-2:0], miso};
  // With cpha=1 the final sample lands on the same edge that ends the word.
  assign rx_word  = cpha_l ? rx_next : rx_sh;
  assign sample   = ~edge_cnt[0] ^ cpha_l;
  assign msb_use  = start ? msb_cfg : msb_l;
  assign cpha_use = start ? cfg_cpha : cpha_l;

  always_comb begin
    msb_cfg = IW'(DATA_W - 1);
    if (cfg_len != 6'd0 && 32'(cfg_len) <= DATA_W) msb_cfg = IW'(cfg_len - 6'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    load      = 1'b0;
    rx_push   = 1'b0;
    case (state)
      IDLE:  if (!tx_empty && !rx_full) begin
               state_nxt = SETUP;
               start     = 1'b1;
             end
      SETUP: if (tick) state_nxt = XFER;
      XFER:  if (tick && edge_cnt == {msb_l, 1'b1}) begin
               state_nxt = HOLD;
               rx_push   = 1'b1;
             end
      HOLD:  if (tick) begin
               if (tx_empty) state_nxt = GAP;
               else if (!rx_full) begin
                 state_nxt = XFER;
                 load      = 1'b1;
               end
             end
      GAP:   if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
      div_l    <= '0;
      msb_l    <= '0;
      cpha_l   <= 1'b0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      sclk     <= 1'b0;
      mosi     <= 1'b1;
      cs_n     <= '1;
    end else begin
      if (state == IDLE || tick) div_cnt <= '0;
      else                       div_cnt <= div_cnt + 1'b1;

      if (state == IDLE) begin
        sclk <= cfg_cpol;
        mosi <= 1'b1;
      end

      if (start) begin
        div_l  <= cfg_div;
        msb_l  <= msb_cfg;
        cpha_l <= cfg_cpha;
        cs_n   <= ~(NCS'(1) << cfg_cs);
      end

      if (start || load) begin
        tx_sh    <= tx_word;
        rx_sh    <= '0;
        edge_cnt <= '0;
        if (!cpha_use) mosi <= tx_word[msb_use];
      end else if (state == XFER && tick) begin
        sclk     <= ~sclk;
        edge_cnt <= edge_cnt + 1'b1;
        if (sample) rx_sh <= rx_next;
        else begin
          mosi  <= cpha_l ? tx_sh[msb_l] : tx_next[msb_l];
          tx_sh <= tx_next;
        end
      end

      if (state == HOLD && state_nxt == GAP) begin
        cs_n <= '1;
        mosi <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_spi_master_fifo.sv
// tb/tb_spi_master_fifo.sv - scoreboard bench for spi_master_fifo
module tb_spi_master_fifo;
  localparam int DATA_W = 32;
  localparam int NCS    = 4;
  localparam int DIV_W  = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [DIV_W-1:0]  cfg_div;
  logic              cfg_cpol, cfg_cpha;
  logic [5:0]        cfg_len;
  logic [1:0]        cfg_cs;
  logic [DATA_W-1:0] tx_data, rx_data;
  logic              tx_valid, tx_ready, rx_valid, rx_ready, busy;
  logic              miso, mosi, sclk;
  logic [NCS-1:0]    cs_n;
  logic              loop_en, miso_tie;

  assign miso = loop_en ? mosi : miso_tie;
  always #5 clk = ~clk;

  spi_master_fifo #(.DATA_W(DATA_W), .NCS(NCS), .DIV_W(DIV_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cfg_div(cfg_div), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
    .cfg_len(cfg_len), .cfg_cs(cfg_cs), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .miso(miso), .mosi(mosi), .sclk(sclk), .cs_n(cs_n)
  );

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [63:0] mon_bits = '0;
  int          mon_cnt = 0;
  int          period = 0;
  int          last_samp = -1;
  logic        prev_sclk = 1'b0;
  logic        prev_cs_low = 1'b0;
  logic [3:0]  last_cs_low = 4'hF;
  int          cs_low_cyc = 0;
  int          cs_rise = 0;
  int          busy_cyc = 0;
  logic        samp_lvl = 1'b1;
  logic [31:0] exp_q[$];
  int          rd_idx = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lmask(input int len);
    int l;
    l = (len == 0 || len > 32) ? 32 : len;
    return (l == 32) ? 32'hFFFF_FFFF : ((32'h1 << l) - 32'h1);
  endfunction

  // Sample at negedge (serial monitor + scoreboard), then return at posedge+1 for driving.
  task automatic tick();
    @(negedge clk);
    if (sclk !== prev_sclk && cs_n !== 4'hF && sclk === samp_lvl) begin
      mon_bits = {mon_bits[62:0], mosi};
      mon_cnt++;
      if (last_samp >= 0) period = cyc - last_samp;
      last_samp = cyc;
    end
    prev_sclk = sclk;
    if (cs_n !== 4'hF) begin
      cs_low_cyc++;
      last_cs_low = cs_n;
    end else if (prev_cs_low) cs_rise++;
    prev_cs_low = (cs_n !== 4'hF);
    if (busy === 1'b1) busy_cyc++;
    if (rx_valid === 1'b1 && rx_ready) begin
      if (rd_idx < exp_q.size()) begin
        check("rx_data", 64'(rx_data), 64'(exp_q[rd_idx]));
        rd_idx++;
      end else check("rx_unexpected", 64'(rx_data), 64'h1_0000_0000);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input logic cpol, input logic cpha, input logic [5:0] len,
                          input logic [7:0] div, input logic [1:0] cs);
    cfg_cpol = cpol; cfg_cpha = cpha; cfg_len = len; cfg_div = div; cfg_cs = cs;
    samp_lvl = ~(cpol ^ cpha);
    repeat (2) tick();
  endtask

  task automatic push(input logic [31:0] d, input bit expect_rx, input int len);
    int n = 0;
    tx_data = d;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && n < 500) begin tick(); n++; end
    if (n >= 500) check("push_timeout", 64'(tx_ready), 64'd1);
    tick();
    tx_valid = 1'b0;
    if (expect_rx) exp_q.push_back(d & lmask(len));
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    repeat (3) tick();
    while (busy !== 1'b0 && n < 5000) begin tick(); n++; end
    if (n >= 5000) check({tag, "_timeout"}, 64'(busy), 64'd0);
    tick();
  endtask

  task automatic wait_bits(input int base, input int nb);
    int n = 0;
    while (mon_cnt - base < nb && n < 2000) begin tick(); n++; end
    if (n >= 2000) check("bits_timeout", 64'(mon_cnt - base), 64'(nb));
  endtask

  initial begin
    int b0, cl0, bc0, cr0;
    logic [31:0] w;
    rst = 1'b1; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
    loop_en = 1'b0; miso_tie = 1'b0;
    cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_len = 6'd8; cfg_div = '0; cfg_cs = '0;
    repeat (2) tick();
    check("rst_cs_n", 64'(cs_n), 64'hF);
    check("rst_mosi", 64'(mosi), 64'd1);
    check("rst_sclk", 64'(sclk), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_tx_ready", 64'(tx_ready), 64'd0);
    check("rst_rx_valid", 64'(rx_valid), 64'd0);
    rst = 1'b0;
    tick();
    check("tx_ready_after_rst", 64'(tx_ready), 64'd1);

    // Mode 0, len 8, div 0, loopback
    set_mode(1'b0, 1'b0, 6'd8, 8'd0, 2'd0);
    loop_en = 1'b1; rx_ready = 1'b1;
    b0 = mon_cnt; cl0 = cs_low_cyc; bc0 = busy_cyc;
    push(32'hA5, 1'b1, 8);
    wait_done("t1");
    check("t1_edges", 64'(mon_cnt - b0), 64'd8);
    check("t1_mosi", 64'(mon_bits[7:0]), 64'hA5);
    check("t1_cs_sel", 64'(last_cs_low), 64'b1110);
    check("t1_cs_low_cyc", 64'(cs_low_cyc - cl0), 64'd18);
    check("t1_busy_cyc", 64'(busy_cyc - bc0), 64'd19);
    check("t1_rx_drained", 64'(rd_idx), 64'(exp_q.size()));

    // Mode 3, len 16, div 3, miso tied high
    loop_en = 1'b0; miso_tie = 1'b1;
    set_mode(1'b1, 1'b1, 6'd16, 8'd3, 2'd1);
    check("t2_sclk_idle", 64'(sclk), 64'd1);
    b0 = mon_cnt; cl0 = cs_low_cyc;
    push(32'h1234, 1'b0, 16);
    exp_q.push_back(32'h0000_FFFF);
    wait_done("t2");
    check("t2_edges", 64'(mon_cnt - b0), 64'd16);
    check("t2_mosi", 64'(mon_bits[15:0]), 64'h1234);
    check("t2_period", 64'(period), 64'd8);
    check("t2_cs_sel", 64'(last_cs_low), 64'b1101);
    check("t2_cs_low_cyc", 64'(cs_low_cyc - cl0), 64'd136);

    // Mode 1, len 32, div 1, four back-to-back words
    loop_en = 1'b1;
    set_mode(1'b0, 1'b1, 6'd32, 8'd1, 2'd3);
    b0 = mon_cnt; cl0 = cs_low_cyc; cr0 = cs_rise;
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      push(w, 1'b1, 32);
    end
    wait_done("t3");
    check("t3_edges", 64'(mon_cnt - b0), 64'd128);
    check("t3_cs_rises", 64'(cs_rise - cr0), 64'd1);
    check("t3_cs_low_cyc", 64'(cs_low_cyc - cl0), 64'd522);
    check("t3_cs_sel", 64'(last_cs_low), 64'b0111);
    check("t3_rx_drained", 64'(rd_idx), 64'(exp_q.size()));

    // RX back-pressure: 6 words, 4-deep RX FIFO
    rx_ready = 1'b0;
    set_mode(1'b0, 1'b0, 6'd8, 8'd0, 2'd2);
    b0 = mon_cnt; cr0 = cs_rise;
    for (int i = 0; i < 6; i++) begin
      w = $urandom;
      push(w, 1'b1, 8);
    end
    repeat (100) tick();
    check("t4_bits_stalled", 64'(mon_cnt - b0), 64'd32);
    check("t4_busy", 64'(busy), 64'd1);
    check("t4_cs_held", 64'(cs_n), 64'b1011);
    check("t4_rx_pending", 64'(exp_q.size() - rd_idx), 64'd6);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    repeat (40) tick();
    check("t4_bits_resumed", 64'(mon_cnt - b0), 64'd40);
    check("t4_cs_still_low", 64'(cs_n), 64'b1011);
    rx_ready = 1'b1;
    wait_done("t4");
    check("t4_bits_total", 64'(mon_cnt - b0), 64'd48);
    check("t4_cs_rises", 64'(cs_rise - cr0), 64'd1);
    check("t4_rx_drained", 64'(rd_idx), 64'(exp_q.size()));

    // Reset mid-word
    set_mode(1'b0, 1'b0, 6'd8, 8'd1, 2'd0);
    b0 = mon_cnt;
    push(32'h3C, 1'b0, 8);
    wait_bits(b0, 3);
    rst = 1'b1;
    tick();
    check("t5_cs_n", 64'(cs_n), 64'hF);
    check("t5_mosi", 64'(mosi), 64'd1);
    check("t5_sclk", 64'(sclk), 64'd0);
    check("t5_rx_valid", 64'(rx_valid), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    repeat (30) tick();
    check("t5_no_partial_rx", 64'(rx_valid), 64'd0);
    check("t5_idle", 64'(busy), 64'd0);

    // cfg_len=0 means full width; cfg changes mid-frame are ignored
    set_mode(1'b0, 1'b0, 6'd0, 8'd0, 2'd0);
    b0 = mon_cnt;
    push(32'hDEAD_BEEF, 1'b1, 0);
    wait_bits(b0, 5);
    cfg_cpol = 1'b1;
    cfg_len = 6'd8;
    wait_done("t6");
    check("t6_edges", 64'(mon_cnt - b0), 64'd32);
    check("t6_mosi", 64'(mon_bits[31:0]), 64'hDEAD_BEEF);
    repeat (2) tick();
    check("t6_sclk_new_idle", 64'(sclk), 64'd1);
    check("sb_drained", 64'(rd_idx), 64'(exp_q.size()));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
